// File: rtl/param_block_ram.sv
// param_block_ram: word-addressed block RAM with a read/write port A
// (byte enables, read-first) and a read-only port B. After reset a clear
// engine zeroes every word before either port is serviced. Accesses outside
// the [BASE_ADDR, BASE_ADDR + 2^DEPTH_LOG2 - 1] window raise a one-cycle error.
module param_block_ram #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 16,
   parameter int                DEPTH_LOG2 = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h8000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     addr_a,
   input  logic [DATA_W-1:0]     data_in_a,
   input  logic [DATA_W/8-1:0]   write_enable_a,
   input  logic                  en_a,
   output logic [DATA_W-1:0]     data_out_a,
   output logic                  err_a,
   input  logic [ADDR_W-1:0]     addr_b,
   input  logic                  en_b,
   output logic [DATA_W-1:0]     data_out_b,
   output logic                  err_b,
   output logic                  busy
);

   localparam int NBYTES = DATA_W / 8;
   localparam int DEPTH  = 1 << DEPTH_LOG2;

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   logic [DATA_W-1:0]     mem [0:DEPTH-1];

   state_t                state_q;
   logic [DEPTH_LOG2-1:0] cnt_q;
   logic                  busy_q;
   logic [DATA_W-1:0]     dout_a_q, dout_b_q;
   logic                  err_a_q, err_b_q;

   logic [ADDR_W-1:0]     diff_a_d, diff_b_d;
   logic                  in_a_d, in_b_d;
   logic [DEPTH_LOG2-1:0] idx_a_d, idx_b_d;
   logic                  run_d;

   // Window decode: a single unsigned subtract makes addresses below the base
   // wrap to huge offsets, so one upper-bits-zero test covers both bounds.
   always_comb begin
      diff_a_d = addr_a - BASE_ADDR;
      diff_b_d = addr_b - BASE_ADDR;
      in_a_d   = (diff_a_d[ADDR_W-1:DEPTH_LOG2] == '0);
      in_b_d   = (diff_b_d[ADDR_W-1:DEPTH_LOG2] == '0);
      idx_a_d  = diff_a_d[DEPTH_LOG2-1:0];
      idx_b_d  = diff_b_d[DEPTH_LOG2-1:0];
      run_d    = reset && (state_q == READY);
   end

   // Array writes: clear engine owns the array until READY, then port A bytes.
   // Nothing is written while reset is held low.
   always_ff @(posedge clk) begin
      if (reset && state_q == CLEAR) begin
         mem[cnt_q] <= '0;
      end else if (run_d && en_a && in_a_d) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (write_enable_a[i]) mem[idx_a_d][8*i +: 8] <= data_in_a[8*i +: 8];
         end
      end
   end

   // Clear FSM and registered port outputs; reads sample the array before this
   // edge's write lands, giving read-first on A and old-data on an A/B collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= CLEAR;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
         dout_a_q <= '0;
         dout_b_q <= '0;
         err_a_q  <= 1'b0;
         err_b_q  <= 1'b0;
      end else begin
         err_a_q <= 1'b0;
         err_b_q <= 1'b0;
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               if (en_a) begin
                  if (in_a_d) begin
                     dout_a_q <= mem[idx_a_d];
                  end else begin
                     dout_a_q <= '0;
                     err_a_q  <= 1'b1;
                  end
               end
               if (en_b) begin
                  if (in_b_d) begin
                     dout_b_q <= mem[idx_b_d];
                  end else begin
                     dout_b_q <= '0;
                     err_b_q  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign data_out_a = dout_a_q;
   assign data_out_b = dout_b_q;
   assign err_a      = err_a_q;
   assign err_b      = err_b_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_param_block_ram.sv
// Bench for param_block_ram (default parameters): clear timing, table of
// port A/B vectors through a scoreboard queue, and reset-restart sequences.
module tb_param_block_ram;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr_a, addr_b;
   logic [31:0] data_in_a;
   logic [3:0]  write_enable_a;
   logic        en_a, en_b;
   logic [31:0] data_out_a, data_out_b;
   logic        err_a, err_b, busy;

   int total = 0;
   int bad   = 0;

   param_block_ram dut (
      .clk(clk), .reset(reset),
      .addr_a(addr_a), .data_in_a(data_in_a), .write_enable_a(write_enable_a),
      .en_a(en_a), .data_out_a(data_out_a), .err_a(err_a),
      .addr_b(addr_b), .en_b(en_b), .data_out_b(data_out_b), .err_b(err_b),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en_a;
      logic [15:0] addr_a;
      logic [31:0] din;
      logic [3:0]  we;
      logic        en_b;
      logic [15:0] addr_b;
      logic [31:0] xa;
      logic        xea;
      logic [31:0] xb;
      logic        xeb;
   } vec_t;

   typedef struct {
      logic        chk_a;
      logic [31:0] da;
      logic        ea;
      logic        chk_b;
      logic [31:0] db;
      logic        eb;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Drive one access at the falling edge, queue its expectation, then pop and
   // compare just after the rising edge that registers the result.
   task automatic access(input string nm, input logic ea_i, input logic [15:0] aa,
                         input logic [31:0] din, input logic [3:0] we,
                         input logic eb_i, input logic [15:0] ab, input exp_t e);
      exp_t got;
      @(negedge clk);
      en_a = ea_i; addr_a = aa; data_in_a = din; write_enable_a = we;
      en_b = eb_i; addr_b = ab;
      sb.push_back(e);
      @(posedge clk); #1;
      got = sb.pop_front();
      if (got.chk_a) begin
         chk({nm, ".da"}, data_out_a, got.da);
         chk({nm, ".ea"}, {31'b0, err_a}, {31'b0, got.ea});
      end
      if (got.chk_b) begin
         chk({nm, ".db"}, data_out_b, got.db);
         chk({nm, ".eb"}, {31'b0, err_b}, {31'b0, got.eb});
      end
   endtask

   // Count falling edges with busy high starting at the release edge.
   task automatic count_busy(input string nm, input int want);
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk(nm, n, want);
   endtask

   exp_t e;
   int   leak;

   initial begin
      reset = 1'b0; en_a = 0; en_b = 0; addr_a = 0; addr_b = 0;
      data_in_a = 0; write_enable_a = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.busy", {31'b0, busy}, 32'd1);
      chk("rst.da", data_out_a, 32'h0);
      chk("rst.db", data_out_b, 32'h0);
      chk("rst.ea", {31'b0, err_a}, 32'd0);
      chk("rst.eb", {31'b0, err_b}, 32'd0);

      // Release; requests during the clear must be dropped.
      reset = 1'b1;
      en_a = 1; addr_a = 16'h8000; data_in_a = 32'hFFFFFFFF; write_enable_a = 4'hF;
      en_b = 1; addr_b = 16'h7000;
      begin
         int n = 0;
         leak = 0;
         while (busy === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
            if (busy === 1'b1 && (err_a !== 0 || err_b !== 0 ||
                data_out_a !== 0 || data_out_b !== 0)) leak++;
         end
         chk("clear.cycles", n, 1024);
         chk("clear.dropped", leak, 0);
      end
      en_a = 0; en_b = 0; write_enable_a = 0;

      // Every word reads back zero via port B.
      e = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
      for (int i = 0; i < 1024; i++)
         access($sformatf("scan%0d", i), 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h8000 + 16'(i), e);

      //           en_a addr_a   din           we     en_b addr_b   xa            xea  xb            xeb
      tbl[0]  = '{1'b1, 16'h8000, 32'hFFFFFFFF, 4'hF, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      tbl[1]  = '{1'b1, 16'h8000, 32'hBBDAB777, 4'h5, 1'b0, 16'h0000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
      tbl[2]  = '{1'b1, 16'h8000, 32'h00000000, 4'h0, 1'b0, 16'h0000, 32'hFFDAFF77, 1'b0, 32'h00000000, 1'b0};
      tbl[3]  = '{1'b1, 16'h7FFF, 32'h12345678, 4'hF, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
      tbl[4]  = '{1'b1, 16'h8400, 32'h12345678, 4'hF, 1'b0, 16'h0000, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
      tbl[5]  = '{1'b1, 16'h83FF, 32'h00000000, 4'h0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      tbl[6]  = '{1'b1, 16'h8000, 32'h00000000, 4'h0, 1'b0, 16'h0000, 32'hFFDAFF77, 1'b0, 32'h00000000, 1'b0};
      tbl[7]  = '{1'b1, 16'h805B, 32'hA5A5A5A5, 4'hF, 1'b1, 16'h805B, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      tbl[8]  = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 1'b1, 16'h805B, 32'h00000000, 1'b0, 32'hA5A5A5A5, 1'b0};
      tbl[9]  = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 1'b1, 16'h7FFF, 32'h00000000, 1'b0, 32'h00000000, 1'b1};
      tbl[10] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 1'b1, 16'h8400, 32'h00000000, 1'b0, 32'h00000000, 1'b1};
      tbl[11] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 1'b1, 16'h8000, 32'h00000000, 1'b0, 32'hFFDAFF77, 1'b0};
      tbl[12] = '{1'b1, 16'h8123, 32'hCAFEF00D, 4'hF, 1'b0, 16'h0000, 32'h00000000, 1'b0, 32'hFFDAFF77, 1'b0};
      tbl[13] = '{1'b1, 16'h8123, 32'h00000000, 4'h0, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b0, 32'hFFDAFF77, 1'b0};
      tbl[14] = '{1'b0, 16'h8123, 32'h00000000, 4'h0, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b0, 32'hFFDAFF77, 1'b0};
      tbl[15] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 1'b1, 16'hFFFF, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b1};
      tbl[16] = '{1'b1, 16'h8123, 32'h11111111, 4'h0, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b0};
      tbl[17] = '{1'b1, 16'h8123, 32'h5A000000, 4'h8, 1'b0, 16'h0000, 32'hCAFEF00D, 1'b0, 32'h00000000, 1'b0};
      tbl[18] = '{1'b1, 16'h8123, 32'h00000000, 4'h0, 1'b1, 16'h8123, 32'h5AFEF00D, 1'b0, 32'h5AFEF00D, 1'b0};
      tbl[19] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 1'b0, 16'h0000, 32'h5AFEF00D, 1'b0, 32'h5AFEF00D, 1'b0};

      for (int i = 0; i < 20; i++) begin
         e = '{1'b1, tbl[i].xa, tbl[i].xea, 1'b1, tbl[i].xb, tbl[i].xeb};
         access($sformatf("row%0d", i), tbl[i].en_a, tbl[i].addr_a, tbl[i].din, tbl[i].we,
                tbl[i].en_b, tbl[i].addr_b, e);
      end

      // Reset restart mid-clear.
      e = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      access("pre.wr", 1'b1, 16'h8010, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, e);
      e = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0};
      access("pre.rd", 1'b1, 16'h8010, 32'h0, 4'h0, 1'b0, 16'h0, e);
      @(negedge clk);
      en_a = 0; en_b = 0; write_enable_a = 0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      leak = 0;
      repeat (300) begin
         if (busy !== 1'b1) leak++;
         @(negedge clk);
      end
      chk("mid.busy_held", leak, 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      count_busy("restart.cycles", 1024);
      e = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      access("post.rd", 1'b1, 16'h8010, 32'h0, 4'h0, 1'b0, 16'h0, e);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/param_block_ram.md
Name: param_block_ram

Overview:
- Parametrised successor of the single-port data-memory block RAM.
- Port A: read/write, byte write enables. Port B: independent read-only (e.g. display/DMA readout).
- Built-in post-reset clear engine zeroes the whole array; address-window decode with error flagging.
- Sits in the data-memory region of the system address map, base 0x8000 by default.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 16, width of the word address buses.
- DEPTH_LOG2, 10, log2 of the number of words (default 1024).
- BASE_ADDR, 16'h8000, first valid word address; valid window is [BASE_ADDR, BASE_ADDR+2^DEPTH_LOG2-1].

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- addr_a  in  ADDR_W  port A word address.
- data_in_a  in  DATA_W  port A write data.
- write_enable_a  in  DATA_W/8  port A byte write enables; bit i covers bits [8i+7:8i].
- en_a  in  1  port A access strobe (read, or write if any write_enable_a bit is set).
- data_out_a  out  DATA_W  port A registered read data.
- err_a  out  1  port A out-of-window pulse.
- addr_b  in  ADDR_W  port B word address.
- en_b  in  1  port B read strobe.
- data_out_b  out  DATA_W  port B registered read data.
- err_b  out  1  port B out-of-window pulse.
- busy  out  1  clear engine active; accesses are ignored.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - data_out_a, data_out_b, err_a and err_b go to 0; busy goes to 1.
  - Array contents are not touched while reset is held.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle with reset==1, writes 0 to mem[cnt] and increments cnt.
  - After the write of word 2^DEPTH_LOG2-1, moves to READY.
  - busy is 1 for exactly 2^DEPTH_LOG2 cycles after the first edge with reset==1, then 0.
  - Port requests during CLEAR are dropped: no write, outputs hold 0, no err.
  - Reset asserted mid-clear restarts the clear from word 0.
- READY, window decode:
  - In-window when (addr - BASE_ADDR) < 2^DEPTH_LOG2, computed as an unsigned ADDR_W-bit subtraction.
  - Index is the low DEPTH_LOG2 bits of the difference.
  - Addresses below BASE_ADDR wrap to large values and are therefore out of window.
- Port A, en_a=1, in-window:
  - Bytes with write_enable_a[i]=1 are written at this edge.
  - data_out_a updates at the same edge with the pre-write contents (read-first); latency is 1 cycle.
- Port A, en_a=1, out-of-window:
  - No write; data_out_a <= 0; err_a=1 for one cycle.
- Port B, en_b=1:
  - In-window: data_out_b <= mem[index] at the edge (1-cycle latency).
  - Out-of-window: data_out_b <= 0, err_b=1 for one cycle.
- en=0 on a port: its data_out holds its last value and its err is 0.
- Collision (A writes, B reads the same index in the same cycle): B returns the old data. The new data is visible from the next cycle.
- A write with write_enable_a==0 and en_a=1 is a pure read.
- err_a and err_b are registered and aligned with their data_out update.

Test Plan:
- Release reset with DEPTH_LOG2=10 -> busy stays 1 for exactly 1024 cycles; then B reads of 0x8000..0x83FF all return 0x00000000.
- Write A 0x8000 = 0xFFFFFFFF with we=4'hF, then 0xBBDAB777 with we=4'b0101 -> read of 0x8000 returns 0xFFDAFF77 one cycle after en_a.
- A write 0x7FFF and 0x8400 = 0x12345678 with we=4'hF -> err_a pulses once each, data_out_a=0; a read of 0x83FF is unchanged and err_a=0.
- Same cycle: A writes 0x805B = 0xA5A5A5A5 (prior 0), B reads 0x805B -> data_out_b=0 and data_out_a=0; B read in the next cycle returns 0xA5A5A5A5.
- Write 0x8010 = 0xDEADBEEF, assert reset for 1 cycle, release, then pulse reset again 300 cycles later -> busy high continuously and clear restarts; 1024 cycles after the final release busy=0 and 0x8010 reads 0.
- en_a held 0 after a read of 0xCAFEF00D -> data_out_a holds 0xCAFEF00D and err_a stays 0.
